wb_commit: RTL and testbench

- Write-back/commit stage at the tail of the in-order pipeline.
- Accepts completed instructions from the memory stage through a valid/ready handshake, and waits for variable-latency data-memory load responses.
- Extracts and sign/zero-extends load data, then drives the one-cycle register-file write port (w_enable_WB/w_addr_WB/w_data_WB/pc_WB) consumed by the decode stage. That write also releases the scoreboard ready bits.
- Tracks halt and the retired-instruction count.

---
 rtl/wb_commit.sv | 186 ++++++++++++++++++
 tb/tb_wb_commit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
// Write-back/commit stage: accepts retiring instructions, waits for load data,
// and drives the single-cycle register-file write port plus halt/retire status.
module wb_commit #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MW_valid,
  input  logic [31:0]      MW_pc,
  input  logic [4:0]       MW_rd_addr,
  input  logic             MW_w_enable,
  input  logic             MW_is_load,
  input  logic [2:0]       MW_load_type,
  input  logic [31:0]      MW_result,
  input  logic             MW_is_halt,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output logic             wb_ready,
  output logic             w_enable_WB,
  output logic [4:0]       w_addr_WB,
  output logic [31:0]      w_data_WB,
  output logic [31:0]      pc_WB,
  output logic             is_halted,
  output logic             load_timeout,
  output logic [CNT_W-1:0] retired_count
);

  localparam int unsigned    TW       = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(LOAD_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, WAIT_LOAD, HALTED} state_t;

  state_t             state, state_next;
  logic               accept;
  logic [TW-1:0]      tmo_cnt, tmo_cnt_n;
  logic [4:0]         ld_rd, ld_rd_n;
  logic               ld_wen, ld_wen_n;
  logic [2:0]         ld_type, ld_type_n;
  logic [1:0]         ld_off, ld_off_n;
  logic [31:0]        ld_pc, ld_pc_n;
  logic               w_en_n;
  logic [4:0]         w_addr_n;
  logic [31:0]        w_data_n;
  logic [31:0]        pc_n;
  logic               halted_n;
  logic               timeout_n;
  logic [CNT_W-1:0]   cnt_n;

  function automatic logic [31:0] extract(input logic [2:0] t, input logic [1:0] o,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[7:0];
    case (o)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = o[1] ? d[31:16] : d[15:0];
    case (t)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign wb_ready = (state == RUN);
  assign accept   = MW_valid & wb_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (accept) begin
          if (MW_is_halt)      state_next = HALTED;
          else if (MW_is_load) state_next = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid)               state_next = RUN;
        else if (tmo_cnt == TMO_LAST)  state_next = HALTED;
      end
      default: state_next = HALTED;
    endcase
  end

  // Registered outputs hold by default; only the strobe self-clears.
  always_comb begin
    w_en_n    = 1'b0;
    w_addr_n  = w_addr_WB;
    w_data_n  = w_data_WB;
    pc_n      = pc_WB;
    halted_n  = is_halted;
    timeout_n = load_timeout;
    cnt_n     = retired_count;
    tmo_cnt_n = tmo_cnt;
    ld_rd_n   = ld_rd;
    ld_wen_n  = ld_wen;
    ld_type_n = ld_type;
    ld_off_n  = ld_off;
    ld_pc_n   = ld_pc;
    case (state)
      RUN: begin
        if (accept) begin
          if (MW_is_halt) begin
            pc_n     = MW_pc;
            cnt_n    = retired_count + 1'b1;
            halted_n = 1'b1;
          end else if (MW_is_load) begin
            ld_rd_n   = MW_rd_addr;
            ld_wen_n  = MW_w_enable;
            ld_type_n = MW_load_type;
            ld_off_n  = MW_result[1:0];
            ld_pc_n   = MW_pc;
            tmo_cnt_n = '0;
          end else begin
            w_en_n   = MW_w_enable & (|MW_rd_addr);
            w_addr_n = MW_rd_addr;
            w_data_n = MW_result;
            pc_n     = MW_pc;
            cnt_n    = retired_count + 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          w_en_n   = ld_wen & (|ld_rd);
          w_addr_n = ld_rd;
          w_data_n = extract(ld_type, ld_off, dmem_rdata);
          pc_n     = ld_pc;
          cnt_n    = retired_count + 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout_n = 1'b1;
          halted_n  = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_enable_WB   <= 1'b0;
      w_addr_WB     <= '0;
      w_data_WB     <= '0;
      pc_WB         <= '0;
      is_halted     <= 1'b0;
      load_timeout  <= 1'b0;
      retired_count <= '0;
      tmo_cnt       <= '0;
      ld_rd         <= '0;
      ld_wen        <= 1'b0;
      ld_type       <= '0;
      ld_off        <= '0;
      ld_pc         <= '0;
    end else begin
      w_enable_WB   <= w_en_n;
      w_addr_WB     <= w_addr_n;
      w_data_WB     <= w_data_n;
      pc_WB         <= pc_n;
      is_halted     <= halted_n;
      load_timeout  <= timeout_n;
      retired_count <= cnt_n;
      tmo_cnt       <= tmo_cnt_n;
      ld_rd         <= ld_rd_n;
      ld_wen        <= ld_wen_n;
      ld_type       <= ld_type_n;
      ld_off        <= ld_off_n;
      ld_pc         <= ld_pc_n;
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed and randomized transactions checked against a
// transaction-level model of the expected register-file writes and status.
module tb_wb_commit;

  logic        clk;
  logic        rst;
  logic        MW_valid;
  logic [31:0] MW_pc;
  logic [4:0]  MW_rd_addr;
  logic        MW_w_enable;
  logic        MW_is_load;
  logic [2:0]  MW_load_type;
  logic [31:0] MW_result;
  logic        MW_is_halt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_ready;
  logic        w_enable_WB;
  logic [4:0]  w_addr_WB;
  logic [31:0] w_data_WB;
  logic [31:0] pc_WB;
  logic        is_halted;
  logic        load_timeout;
  logic [3:0]  retired_count;

  int checks = 0;
  int errors = 0;

  logic        exp_wen;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic [31:0] exp_pc;
  logic        exp_halt;
  logic        exp_to;
  int unsigned exp_cnt;

  wb_commit #(.CNT_W(4), .LOAD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .MW_valid(MW_valid), .MW_pc(MW_pc), .MW_rd_addr(MW_rd_addr),
    .MW_w_enable(MW_w_enable), .MW_is_load(MW_is_load), .MW_load_type(MW_load_type),
    .MW_result(MW_result), .MW_is_halt(MW_is_halt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_ready(wb_ready), .w_enable_WB(w_enable_WB), .w_addr_WB(w_addr_WB),
    .w_data_WB(w_data_WB), .pc_WB(pc_WB), .is_halted(is_halted),
    .load_timeout(load_timeout), .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [3:0] c;
    c = 4'(exp_cnt);
    chk({ctx, ".wen"},   w_enable_WB,   exp_wen);
    chk({ctx, ".addr"},  w_addr_WB,     exp_addr);
    chk({ctx, ".data"},  w_data_WB,     exp_data);
    chk({ctx, ".pc"},    pc_WB,         exp_pc);
    chk({ctx, ".halt"},  is_halted,     exp_halt);
    chk({ctx, ".tmo"},   load_timeout,  exp_to);
    chk({ctx, ".count"}, retired_count, c);
  endtask

  // Expected load result from the byte/half selection rules.
  function automatic logic [31:0] ref_load(input logic [2:0] t, input int unsigned off,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (t)
      3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    MW_valid = 0; MW_pc = '0; MW_rd_addr = '0; MW_w_enable = 0; MW_is_load = 0;
    MW_load_type = '0; MW_result = '0; MW_is_halt = 0; dmem_rvalid = 0; dmem_rdata = '0;
  endtask

  task automatic model_reset();
    exp_wen = 0; exp_addr = '0; exp_data = '0; exp_pc = '0;
    exp_halt = 0; exp_to = 0; exp_cnt = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    model_reset();
    #1;
    check_all("rst_async");
    @(negedge clk);
    rst = 0;
    tick();
    check_all("rst_rel");
    chk("rst_ready", wb_ready, 1);
  endtask

  // Presents one ALU instruction for one cycle; MW_valid is left high so that
  // consecutive calls are back-to-back accepts.
  task automatic alu(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                     input logic [31:0] res);
    MW_valid = 1; MW_pc = pc; MW_rd_addr = rd; MW_w_enable = wen; MW_is_load = 0;
    MW_is_halt = 0; MW_result = res;
    chk("alu_ready", wb_ready, 1);
    tick();
    exp_wen = wen && (rd != 0); exp_addr = rd; exp_data = res; exp_pc = pc;
    exp_cnt++;
    check_all("alu");
  endtask

  task automatic idle(input int n);
    MW_valid = 0; dmem_rvalid = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      exp_wen = 0;
      check_all("idle");
    end
  endtask

  task automatic load(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                      input logic [2:0] typ, input logic [31:0] addr,
                      input logic [31:0] rdata, input int lat);
    MW_valid = 1; MW_pc = pc; MW_rd_addr = rd; MW_w_enable = wen; MW_is_load = 1;
    MW_is_halt = 0; MW_load_type = typ; MW_result = addr;
    dmem_rvalid = 1; dmem_rdata = ~rdata;
    chk("ld_ready", wb_ready, 1);
    tick();
    exp_wen = 0;
    check_all("ld_acc");
    chk("ld_acc_ready", wb_ready, 0);
    MW_pc = pc + 32'h100; MW_is_load = 0; MW_rd_addr = 5'd1; MW_w_enable = 1;
    dmem_rvalid = 0;
    for (int i = 1; i < lat; i++) begin
      tick();
      check_all("ld_wait");
      chk("ld_wait_ready", wb_ready, 0);
    end
    dmem_rvalid = 1; dmem_rdata = rdata;
    tick();
    exp_wen = wen && (rd != 0); exp_addr = rd; exp_pc = pc;
    exp_data = ref_load(typ, int'(addr[1:0]), rdata);
    exp_cnt++;
    check_all("ld_resp");
    chk("ld_resp_ready", wb_ready, 1);
    MW_valid = 0; dmem_rvalid = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Back-to-back ALU writes
    alu(32'h10, 5'd5, 1, 32'h1234);
    chk("b2b1_wen", w_enable_WB, 1);
    alu(32'h14, 5'd6, 1, 32'hFFFF_FFFF);
    chk("b2b2_data", w_data_WB, 32'hFFFF_FFFF);
    chk("b2b_count", retired_count, 4'd2);
    idle(2);

    // Directed loads
    load(32'h20, 5'd8, 1, 3'b000, 32'h0000_1003, 32'h80FF_0000, 3);
    chk("lb_data", w_data_WB, 32'hFFFF_FF80);
    idle(1);
    load(32'h24, 5'd9, 1, 3'b101, 32'h0000_1002, 32'h80FF_0000, 1);
    chk("lhu_data", w_data_WB, 32'h0000_80FF);
    load(32'h28, 5'd10, 1, 3'b001, 32'h0000_1002, 32'h80FF_0000, 2);
    chk("lh_data", w_data_WB, 32'hFFFF_80FF);
    idle(1);

    // rd=0 and no-write instructions retire without strobing
    alu(32'h30, 5'd0, 1, 32'hDEAD_BEEF);
    alu(32'h34, 5'd7, 0, 32'hCAFE_0001);
    idle(1);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0)
        alu($urandom & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom);
      else
        load($urandom & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);

    // Halt, with halt and load both set; valid stays high afterwards
    MW_valid = 1; MW_pc = 32'h40; MW_is_halt = 1; MW_is_load = 1; MW_w_enable = 1;
    MW_rd_addr = 5'd9; MW_result = 32'h55;
    tick();
    exp_wen = 0; exp_pc = 32'h40; exp_halt = 1; exp_cnt++;
    check_all("halt");
    MW_is_halt = 0; MW_is_load = 0;
    for (int i = 0; i < 4; i++) begin
      MW_pc = 32'h44 + 32'(4 * i);
      dmem_rvalid = 1'(i);
      tick();
      check_all("halted");
      chk("halted_ready", wb_ready, 0);
    end

    // Load timeout after exactly 4 wait cycles
    do_reset();
    MW_valid = 1; MW_pc = 32'h60; MW_rd_addr = 5'd3; MW_w_enable = 1; MW_is_load = 1;
    MW_load_type = 3'b010; MW_result = 32'h100;
    tick();
    check_all("tmo_acc");
    MW_valid = 0; MW_is_load = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("tmo_wait");
      chk("tmo_wait_ready", wb_ready, 0);
    end
    tick();
    exp_to = 1; exp_halt = 1;
    check_all("tmo_fire");
    dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    tick();
    check_all("tmo_after");
    chk("tmo_ready", wb_ready, 0);

    // Asynchronous reset during a pending load
    do_reset();
    alu(32'h70, 5'd4, 1, 32'hABCD_0000);
    load(32'h74, 5'd11, 1, 3'b010, 32'h200, 32'h1357_9BDF, 1);
    MW_valid = 1; MW_pc = 32'h78; MW_rd_addr = 5'd12; MW_is_load = 1; MW_result = 32'h204;
    tick();
    MW_valid = 0; MW_is_load = 0;
    tick();
    #2;
    rst = 1;
    model_reset();
    #1;
    check_all("midload_rst");
    @(negedge clk);
    rst = 0;
    dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid = 0;
    check_all("midload_after");
    chk("midload_ready", wb_ready, 1);

    // Retire counter wraps after 16 retires
    do_reset();
    for (int i = 0; i < 16; i++)
      alu(32'h1000 + 32'(4 * i), 5'($urandom_range(0, 31)), 1, $urandom);
    idle(1);
    chk("wrap_count", retired_count, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
